// File: rtl/zacore_imem_bridge_if.sv
// Bus interfaces around zacore_imem_bridge: the fetch-side request/ack port
// and the split address/response instruction-memory port.

interface zacore_fetch_if;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ack;
  logic [31:0] inst_read;
  logic        invalidate;

  modport master (
    output fetch_req,
    output fetch_addr,
    output invalidate,
    input  fetch_ack,
    input  inst_read
  );

  modport slave (
    input  fetch_req,
    input  fetch_addr,
    input  invalidate,
    output fetch_ack,
    output inst_read
  );
endinterface

interface zacore_imem_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_err;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_gnt,
    input  mem_rvalid,
    input  mem_rdata,
    input  mem_err
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_gnt,
    output mem_rvalid,
    output mem_rdata,
    output mem_err
  );
endinterface

// File: rtl/zacore_imem_bridge.sv
// Instruction-memory bridge between zacore_fetch and a split address/response bus.
// Optional one-word last-fetch buffer enabled by `define ZACORE_IMEM_LASTWORD_EN.

module zacore_imem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] RESET_NOP      = 32'h0000_0013
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  zacore_fetch_if.slave fetch_if,
  zacore_imem_if.master mem_if,
  output logic          o_bus_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_addr_q;
  logic [31:0] r_inst_q;
  logic        r_discard;
  logic [15:0] r_cnt;
  logic        r_bus_err;

  logic        w_addr_match;
  logic        w_stale;
  logic        w_kill;
  logic        w_timeout;
  logic        w_ack;
  logic        w_capture;
  logic        w_rsp_load;
  logic        w_err_evt;

  assign w_addr_match = (fetch_if.fetch_addr[31:2] == r_addr_q[31:2]);
  assign w_stale      = fetch_if.invalidate | (fetch_if.fetch_req & ~w_addr_match);
  assign w_kill       = r_discard | w_stale;
  assign w_timeout    = (r_cnt == TIMEOUT_LAST);
  assign w_ack        = (r_state == ST_RESP) & fetch_if.fetch_req & w_addr_match &
                        ~fetch_if.invalidate;

`ifdef ZACORE_IMEM_LASTWORD_EN
  logic        r_lw_valid;
  logic [29:0] r_lw_tag;
  logic [31:0] r_lw_word;
  logic        w_lw_hit;

  assign w_lw_hit = r_lw_valid & (r_lw_tag == fetch_if.fetch_addr[31:2]);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_rsp_load  = 1'b0;
    w_err_evt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (fetch_if.fetch_req && !fetch_if.invalidate) begin
          w_capture = 1'b1;
`ifdef ZACORE_IMEM_LASTWORD_EN
          w_state_nxt = w_lw_hit ? ST_RESP : ST_REQ;
`else
          w_state_nxt = ST_REQ;
`endif
        end
      end
      ST_REQ: begin
        if (mem_if.mem_gnt) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A response on the final counted cycle still wins over the timeout.
        if (mem_if.mem_rvalid) begin
          if (mem_if.mem_err) begin
            w_err_evt   = 1'b1;
            w_state_nxt = ST_IDLE;
          end else if (w_kill) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_rsp_load  = 1'b1;
            w_state_nxt = ST_RESP;
          end
        end else if (w_timeout) begin
          w_err_evt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (fetch_if.invalidate || fetch_if.fetch_req) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr_q  <= '0;
      r_inst_q  <= RESET_NOP;
      r_discard <= 1'b0;
      r_cnt     <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= w_err_evt;

      if (w_capture) begin
        r_addr_q <= fetch_if.fetch_addr & ~32'h3;
      end

      if (w_rsp_load) begin
        r_inst_q <= mem_if.mem_rdata;
      end
`ifdef ZACORE_IMEM_LASTWORD_EN
      else if (w_capture && w_lw_hit) begin
        r_inst_q <= r_lw_word;
      end
`endif

      // Stale transactions still run to completion on the bus; only the data is dropped.
      if (w_state_nxt == ST_IDLE) begin
        r_discard <= 1'b0;
      end else if (((r_state == ST_REQ) || (r_state == ST_WAIT)) && w_stale) begin
        r_discard <= 1'b1;
      end

      if ((r_state == ST_REQ) && mem_if.mem_gnt) begin
        r_cnt <= '0;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

`ifdef ZACORE_IMEM_LASTWORD_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lw_valid <= 1'b0;
      r_lw_tag   <= '0;
      r_lw_word  <= '0;
    end else if (fetch_if.invalidate) begin
      r_lw_valid <= 1'b0;
    end else if (w_rsp_load) begin
      r_lw_valid <= 1'b1;
      r_lw_tag   <= r_addr_q[31:2];
      r_lw_word  <= mem_if.mem_rdata;
    end
  end
`endif

  assign mem_if.mem_req     = (r_state == ST_REQ);
  assign mem_if.mem_addr    = r_addr_q;
  assign fetch_if.fetch_ack = w_ack;
  assign fetch_if.inst_read = r_inst_q;
  assign o_bus_err          = r_bus_err;

endmodule

// File: tb/tb_zacore_imem_bridge.sv
// Self-checking bench for zacore_imem_bridge: vector table, hand sequences for
// redirect/stall/last-word/reset, and randomized fetches against a transaction model.

module tb_zacore_imem_bridge;

  localparam int unsigned T   = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic busErr;

  zacore_fetch_if fetchIf();
  zacore_imem_if  memIf();

  zacore_imem_bridge #(
    .TIMEOUT_CYCLES(T),
    .RESET_NOP     (NOP)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rstN),
    .fetch_if (fetchIf),
    .mem_if   (memIf),
    .o_bus_err(busErr)
  );

  always #5 clk = ~clk;

  int vecCount  = 0;
  int missCount = 0;

  // Memory responder state: grant after mGntDelay request cycles, data mRvDelay cycles after the first possible slot.
  int          mGntDelay = 0;
  int          mRvDelay  = 0;
  bit          mErr      = 1'b0;
  int          mReqSeen  = 0;
  bit          mPending  = 1'b0;
  int          mRvCnt    = 0;
  logic [31:0] mAddrQ    = '0;

  logic        obsAck;
  logic [31:0] obsInst;
  logic        obsMemReq;
  logic [31:0] obsMemAddr;
  logic        obsBusErr;

`ifdef ZACORE_IMEM_LASTWORD_EN
  bit          lwValid = 1'b0;
  logic [29:0] lwTag   = '0;
  logic [31:0] lwWord  = '0;
`endif

  typedef struct {
    logic [31:0] addr;
    int          g;
    int          r;
    bit          err;
    int          expAck;
    int          expErr;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return {a[15:0] ^ 16'h5A3C, a[15:0]} ^ 32'h0000_0013;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic modelFill(input logic [31:0] addr);
`ifdef ZACORE_IMEM_LASTWORD_EN
    lwValid = 1'b1;
    lwTag   = addr[31:2];
    lwWord  = memWord(addr & ~32'h3);
`else
    if (addr[0] === 1'bx) $display("[TB] note: unknown address");
`endif
  endtask

  task automatic modelInvalidate();
`ifdef ZACORE_IMEM_LASTWORD_EN
    lwValid = 1'b0;
`endif
  endtask

  // One clock: drive at negedge, sample 1 ns later, then advance the memory responder at posedge.
  task automatic applyStimulus(input logic req, input logic [31:0] addr, input logic inv);
    logic gnt;
    logic rv;
    @(negedge clk);
    gnt = memIf.mem_req && (mReqSeen == mGntDelay);
    rv  = mPending && (mRvCnt == mRvDelay);
    memIf.mem_gnt       = gnt;
    memIf.mem_rvalid    = rv;
    memIf.mem_rdata     = rv ? memWord(mAddrQ) : $urandom;
    memIf.mem_err       = rv & mErr;
    fetchIf.fetch_req   = req;
    fetchIf.fetch_addr  = addr;
    fetchIf.invalidate  = inv;
    #1;
    obsAck     = fetchIf.fetch_ack;
    obsInst    = fetchIf.inst_read;
    obsMemReq  = memIf.mem_req;
    obsMemAddr = memIf.mem_addr;
    obsBusErr  = busErr;
    @(posedge clk);
    if (rv) mPending = 1'b0;
    else if (mPending) mRvCnt++;
    if (gnt) begin
      mPending = 1'b1;
      mRvCnt   = 0;
      mReqSeen = 0;
      mAddrQ   = obsMemAddr;
    end else if (obsMemReq) begin
      mReqSeen++;
    end
  endtask

  task automatic runTxn(input string name, input logic [31:0] addr, input int g, input int r,
                        input bit err, input int expAck, input int expErr, input int expMemReq,
                        input logic [31:0] expData);
    int          ackCyc   = -1;
    int          errCyc   = -1;
    int          reqCyc   = 0;
    int          addrBad  = 0;
    int          spurious = 0;
    logic [31:0] ackData  = '0;
    logic        req;
    mGntDelay = g;
    mRvDelay  = r;
    mErr      = err;
    for (int c = 0; c < 48; c++) begin
      req = (expErr < 0) || (c < expErr);
      applyStimulus(req, addr, 1'b0);
      if (obsMemReq) begin
        reqCyc++;
        if (obsMemAddr !== (addr & ~32'h3)) addrBad++;
      end
      if (obsBusErr && errCyc < 0) errCyc = c;
      if (obsAck && ackCyc < 0) begin
        ackCyc  = c;
        ackData = obsInst;
      end
      if (obsAck) break;
      if (expErr >= 0 && c >= expErr) break;
    end
    for (int d = 0; d < 30 && mPending; d++) begin
      applyStimulus(1'b0, addr, 1'b0);
      if (obsAck || obsBusErr) spurious++;
    end
    checkOutput({name, ".ackCycle"}, ackCyc, expAck);
    if (expAck >= 0) checkOutput({name, ".ackData"}, ackData, expData);
    checkOutput({name, ".busErrCycle"}, errCyc, expErr);
    checkOutput({name, ".memReqCycles"}, reqCyc, expMemReq);
    checkOutput({name, ".memAddrStable"}, addrBad, 0);
    checkOutput({name, ".lateQuiet"}, spurious, 0);
  endtask

  // Transaction-level reference: a hit is served in one cycle, otherwise the
  // outcome is fixed by grant delay, response delay, error flag and timeout.
  task automatic modelTxn(input string name, input logic [31:0] addr, input int g, input int r,
                          input bit err);
    bit hit = 1'b0;
`ifdef ZACORE_IMEM_LASTWORD_EN
    hit = lwValid && (lwTag == addr[31:2]);
`endif
    if (hit) begin
      runTxn(name, addr, g, r, err, 1, -1, 0, memWord(addr & ~32'h3));
    end else if (r >= int'(T)) begin
      runTxn(name, addr, g, r, err, -1, 2 + g + int'(T), g + 1, '0);
    end else if (err) begin
      runTxn(name, addr, g, r, err, -1, 3 + g + r, g + 1, '0);
    end else begin
      runTxn(name, addr, g, r, err, 3 + g + r, -1, g + 1, memWord(addr & ~32'h3));
      modelFill(addr);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          ackCyc;
    int          errCnt;
    int          reqCyc;
    int          ackDuring;
    int          badHold;
    logic [31:0] ackData;
    logic [31:0] pool[4];

    fetchIf.fetch_req  = 1'b0;
    fetchIf.fetch_addr = '0;
    fetchIf.invalidate = 1'b0;
    memIf.mem_gnt      = 1'b0;
    memIf.mem_rvalid   = 1'b0;
    memIf.mem_rdata    = '0;
    memIf.mem_err      = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset.ack", fetchIf.fetch_ack, 0);
    checkOutput("reset.memReq", memIf.mem_req, 0);
    checkOutput("reset.memAddr", memIf.mem_addr, 0);
    checkOutput("reset.instRead", fetchIf.inst_read, NOP);
    checkOutput("reset.busErr", busErr, 0);
    rstN = 1'b1;

    vecs[0] = '{32'h0000_0100, 0, 0,  1'b0, 3,  -1};
    vecs[1] = '{32'h0000_0204, 3, 4,  1'b0, 10, -1};
    vecs[2] = '{32'h0000_030A, 1, 2,  1'b0, 6,  -1};
    vecs[3] = '{32'h0000_0400, 0, 10, 1'b0, -1, 10};
    vecs[4] = '{32'h0000_0500, 2, 1,  1'b1, -1, 6};
    vecs[5] = '{32'h0000_0604, 0, 7,  1'b0, 10, -1};
    vecs[6] = '{32'h0000_0708, 1, 8,  1'b0, -1, 11};
    for (int i = 0; i < 7; i++) begin
      runTxn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].g, vecs[i].r, vecs[i].err,
             vecs[i].expAck, vecs[i].expErr, vecs[i].g + 1, memWord(vecs[i].addr & ~32'h3));
      if (vecs[i].expAck >= 0) modelFill(vecs[i].addr);
    end

    // Redirect 0x900 -> 0xA00 while WAIT: first response dropped, second fetched and acked.
    mGntDelay = 0;
    mRvDelay  = 3;
    mErr      = 1'b0;
    ackCyc    = -1;
    errCnt    = 0;
    reqCyc    = 0;
    ackData   = '0;
    for (int c = 0; c < 40; c++) begin
      applyStimulus(1'b1, (c < 3) ? 32'h0000_0900 : 32'h0000_0A00, 1'b0);
      if (obsMemReq) reqCyc++;
      if (obsBusErr) errCnt++;
      if (obsAck) begin
        ackCyc  = c;
        ackData = obsInst;
        break;
      end
    end
    checkOutput("redirect.ackCycle", ackCyc, 12);
    checkOutput("redirect.ackData", ackData, memWord(32'h0000_0A00));
    checkOutput("redirect.memReqCycles", reqCyc, 2);
    checkOutput("redirect.busErr", errCnt, 0);
    modelFill(32'h0000_0A00);

    // Fetch stalls four cycles in RESP; data held, ack on return.
    mGntDelay = 0;
    mRvDelay  = 0;
    ackDuring = 0;
    badHold   = 0;
    for (int c = 0; c < 3; c++) applyStimulus(1'b1, 32'h0000_0B00, 1'b0);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, 32'h0000_0B00, 1'b0);
      if (obsAck) ackDuring++;
      if (obsInst !== memWord(32'h0000_0B00)) badHold++;
    end
    applyStimulus(1'b1, 32'h0000_0B00, 1'b0);
    checkOutput("stall.noAck", ackDuring, 0);
    checkOutput("stall.instHeld", badHold, 0);
    checkOutput("stall.ackOnReturn", obsAck, 1);
    checkOutput("stall.ackData", obsInst, memWord(32'h0000_0B00));
    modelFill(32'h0000_0B00);

    // Last-word sequence: 0x40 twice, invalidate, 0x40 again.
    applyStimulus(1'b0, '0, 1'b1);
    modelInvalidate();
    modelTxn("lw.first", 32'h0000_0040, 0, 0, 1'b0);
    modelTxn("lw.second", 32'h0000_0040, 0, 0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1);
    modelInvalidate();
    modelTxn("lw.afterInv", 32'h0000_0040, 0, 0, 1'b0);

    pool[0] = 32'h0000_0040;
    pool[1] = 32'h0000_0044;
    pool[2] = 32'h0000_1080;
    pool[3] = 32'h0001_00C0;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      int          g;
      int          r;
      bit          e;
      a = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
      g = $urandom_range(0, 3);
      r = $urandom_range(0, 9);
      e = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0) begin
        applyStimulus(1'b0, '0, 1'b1);
        modelInvalidate();
      end
      modelTxn($sformatf("rand%0d", i), a, g, r, e);
    end

    // Asynchronous reset in the middle of an address phase.
    mGntDelay = 20;
    applyStimulus(1'b1, 32'h0000_0C00, 1'b0);
    applyStimulus(1'b1, 32'h0000_0C00, 1'b0);
    checkOutput("midReset.reqBefore", obsMemReq, 1);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("midReset.memReq", memIf.mem_req, 0);
    checkOutput("midReset.memAddr", memIf.mem_addr, 0);
    checkOutput("midReset.instRead", fetchIf.inst_read, NOP);
    fetchIf.fetch_req = 1'b0;
    memIf.mem_gnt     = 1'b0;
    mReqSeen          = 0;
    mPending          = 1'b0;
    @(negedge clk);
    rstN = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
